// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encodings for imm_gen and the control decoder that drives imm_sel.
package imm_gen_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 3;

    // Codes 5..7 are reserved and produce a zero immediate.
    typedef enum logic [SEL_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

endpackage

// File: rtl/imm_gen_if.sv
// Decode-stage bus into the immediate generator: instruction word and format select in, immediate out.
interface imm_gen_if
    import imm_gen_pkg::*;
;
    logic [XLEN-1:0]  instr;
    logic [SEL_W-1:0] imm_sel;
    logic [XLEN-1:0]  out;

    modport master (output instr, output imm_sel, input  out);
    modport slave  (input  instr, input  imm_sel, output out);

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: reassembles and sign-extends the I/S/B/U/J immediate of an instruction.
// Define IMMGEN_REG_OUT_EN to register the output (1-cycle latency, synchronous active-high clear).
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    imm_gen_if.slave bus
);

    logic [XLEN-1:0] imm_c;
    logic            sign_c;

    // Opcode bits [6:0] never reach the result; reserved selects yield zero.
    always_comb begin
        imm_c  = '0;
        sign_c = bus.instr[31];
        case (imm_sel_e'(bus.imm_sel))
            IMM_I:   imm_c = {{20{sign_c}}, bus.instr[31:20]};
            IMM_S:   imm_c = {{20{sign_c}}, bus.instr[31:25], bus.instr[11:7]};
            IMM_B:   imm_c = {{19{sign_c}}, bus.instr[31], bus.instr[7],
                              bus.instr[30:25], bus.instr[11:8], 1'b0};
            IMM_U:   imm_c = {bus.instr[31:12], 12'b0};
            IMM_J:   imm_c = {{11{sign_c}}, bus.instr[31], bus.instr[19:12],
                              bus.instr[20], bus.instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

`ifdef IMMGEN_REG_OUT_EN
    logic [XLEN-1:0] out_d;
    logic [XLEN-1:0] out_q;
    logic            unused_opcode;

    assign out_d = imm_c;

    // Reset wins over the load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign bus.out       = out_q;
    assign unused_opcode = ^bus.instr[6:0];
`else
    logic unused_inputs;

    assign bus.out       = imm_c;
    assign unused_inputs = ^{clk, rst, bus.instr[6:0]};
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen; covers both the combinational and the IMMGEN_REG_OUT_EN builds.
module tb_imm_gen;
    import imm_gen_pkg::*;

`ifdef IMMGEN_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    imm_gen_if bus();

    imm_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        drv_vld = 1'b0;
    logic        vld_d1  = 1'b0;
    logic [31:0] exp_v;
    string       nm;

    // Reference model: field extraction with arithmetic shifts and masks on the whole word.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
        int          s;
        logic [31:0] r;
        s = $signed(ins);
        case (sel)
            3'd0: r = 32'(s >>> 20);
            3'd1: r = 32'((s >>> 25) <<< 5) | ((ins >> 7) & 32'h1F);
            3'd2: r = 32'((s >>> 31) <<< 12) | (((ins >> 7) & 32'd1) << 11)
                    | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            3'd3: r = ins & 32'hFFFF_F000;
            3'd4: r = 32'((s >>> 31) <<< 20) | (((ins >> 12) & 32'hFF) << 12)
                    | (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [2:0] sel, input logic r,
                         input logic [31:0] exp_imm, input string tag);
        @(posedge clk);
        #1;
        bus.instr   = ins;
        bus.imm_sel = sel;
        rst         = r;
        drv_vld     = 1'b1;
        exp_q.push_back((REG_OUT && r) ? 32'h0 : exp_imm);
        name_q.push_back(tag);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        drv_vld = 1'b0;
        rst     = 1'b0;
    endtask

    // Delays the stimulus-valid flag by the DUT latency.
    always @(posedge clk) vld_d1 <= drv_vld;

    always @(negedge clk) begin
        if (REG_OUT ? vld_d1 : drv_vld) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: out=%h with no expected entry", bus.out);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if ($isunknown(bus.out) || bus.out !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s: out=%h expected=%h", nm, bus.out, exp_v);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] d_instr [8];
    logic [2:0]  d_sel   [8];
    logic [31:0] d_exp   [8];

    initial begin
        logic [31:0] v;
        logic [2:0]  sel;
        logic        r;

        d_instr[0] = 32'hFFC4A303; d_sel[0] = 3'd0; d_exp[0] = 32'hFFFF_FFFC;
        d_instr[1] = 32'h0064A423; d_sel[1] = 3'd1; d_exp[1] = 32'h0000_0008;
        d_instr[2] = 32'hFE420AE3; d_sel[2] = 3'd2; d_exp[2] = 32'hFFFF_FFF4;
        d_instr[3] = 32'h12345037; d_sel[3] = 3'd3; d_exp[3] = 32'h1234_5000;
        d_instr[4] = 32'hFFDFF06F; d_sel[4] = 3'd4; d_exp[4] = 32'hFFFF_FFFC;
        d_instr[5] = 32'h00A00093; d_sel[5] = 3'd0; d_exp[5] = 32'h0000_000A;
        d_instr[6] = 32'h80000000; d_sel[6] = 3'd2; d_exp[6] = 32'hFFFF_F000;
        d_instr[7] = 32'h80000000; d_sel[7] = 3'd4; d_exp[7] = 32'hFFF0_0000;

        bus.instr   = 32'h0;
        bus.imm_sel = 3'd0;
        rst         = 1'b1;

        // Two reset edges; the combinational build must still follow its inputs.
        apply(32'hFFC4A303, 3'd0, 1'b1, 32'hFFFF_FFFC, "reset_0");
        apply(32'h12345037, 3'd3, 1'b1, 32'h1234_5000, "reset_1");

        // Directed vectors, each repeated with scrambled opcode bits.
        for (int i = 0; i < 8; i++) begin
            apply(d_instr[i], d_sel[i], 1'b0, d_exp[i], $sformatf("directed_%0d", i));
            v      = d_instr[i];
            v[6:0] = 7'($urandom);
            apply(v, d_sel[i], 1'b0, d_exp[i], $sformatf("directed_opc_%0d", i));
        end

        // Reserved selects always give zero.
        for (int k = 5; k < 8; k++) begin
            apply($urandom, 3'(k), 1'b0, 32'h0, $sformatf("reserved_%0d", k));
        end

        // Reset mid-stream, then the very next edge loads the current immediate.
        apply(32'hFFC4A303, 3'd0, 1'b0, 32'hFFFF_FFFC, "pre_midrst");
        apply(32'hFFC4A303, 3'd0, 1'b1, 32'hFFFF_FFFC, "midrst");
        apply(32'h0064A423, 3'd1, 1'b0, 32'h0000_0008, "post_midrst");

        // Random instructions and selects, occasional reset.
        for (int n = 0; n < 400; n++) begin
            v   = $urandom;
            sel = 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 9) == 0);
            apply(v, sel, r, ref_imm(v, sel), $sformatf("random_%0d_sel%0d", n, sel));
        end

        idle();
        idle();
        idle();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected results never observed, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
